pc_unit: RTL

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit_pkg.sv | 30 +++
 rtl/pc_src_mux.sv | 29 ++
 rtl/pc_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared types and constants for the program-counter unit.
//   state_t        - exception-sequence FSM states (RUN, EXC_SAVE, EXC_JUMP)
//   cause_t        - exception cause codes (OPCODE, OVERFLOW, DIV0, ALIGN)
//   DEF_EXC_VEC0-3 - default exception vector per cause
//   sel_width()    - select width for a given channel count, never below 1
package pc_unit_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        EXC_SAVE = 2'd1,
        EXC_JUMP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OPCODE   = 2'd0,
        OVERFLOW = 2'd1,
        DIV0     = 2'd2,
        ALIGN    = 2'd3
    } cause_t;

    localparam logic [31:0] DEF_EXC_VEC0 = 32'h0000_00FC;
    localparam logic [31:0] DEF_EXC_VEC1 = 32'h0000_00FD;
    localparam logic [31:0] DEF_EXC_VEC2 = 32'h0000_00FE;
    localparam logic [31:0] DEF_EXC_VEC3 = 32'h0000_00FF;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pc_src_mux.sv
// pc_src_mux: selects one WIDTH-bit channel out of NSRC packed candidates.
//   sel     in  SELW        channel index
//   data_in in  NSRC*WIDTH  packed channels, channel i at [i*WIDTH +: WIDTH]
//   data    out WIDTH       selected channel, zero when sel is out of range
//   valid   out 1           high when sel < NSRC
module pc_src_mux
    import pc_unit_pkg::*;
#(
    parameter int NSRC  = 5,
    parameter int WIDTH = 32,
    parameter int SELW  = sel_width(NSRC)
) (
    input  logic [SELW-1:0]       sel,
    input  logic [NSRC*WIDTH-1:0] data_in,
    output logic [WIDTH-1:0]      data,
    output logic                  valid
);

    // Loop compare instead of a variable part-select so an out-of-range
    // select yields a clean zero rather than an X.
    always_comb begin
        data  = '0;
        valid = int'(sel) < NSRC;
        for (int i = 0; i < NSRC; i++)
            if (SELW'(i) == sel)
                data = data_in[i*WIDTH +: WIDTH];
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with multi-source load and a two-step exception
// sequence (save EPC/cause, then jump to the per-cause vector).
//   clk           in  1           system clock, rising edge
//   reset         in  1           asynchronous active-high reset
//   pc_src        in  SELW        next-PC channel select
//   src_data      in  NSRC*WIDTH  packed next-PC candidates
//   pc_write      in  1           unconditional load
//   pc_write_cond in  1           conditional load, qualified by cond_true
//   cond_true     in  1           branch condition
//   exc_req       in  1           exception request
//   exc_cause     in  2           exception cause code
//   pc_out        out WIDTH       current PC
//   epc_out       out WIDTH       PC saved on exception entry
//   cause_out     out 2           cause saved on exception entry
//   exc_busy      out 1           exception sequence in progress
//   sel_err       out 1           pulse after a load with an out-of-range select
// Optional feature: define PC_PC_ALIGN_CHECK_EN to raise an ALIGN exception
// instead of loading a target whose bits [1:0] are nonzero.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               NSRC     = 5,
    parameter int               SELW     = sel_width(NSRC),
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] EXC_VEC0 = WIDTH'(DEF_EXC_VEC0),
    parameter logic [WIDTH-1:0] EXC_VEC1 = WIDTH'(DEF_EXC_VEC1),
    parameter logic [WIDTH-1:0] EXC_VEC2 = WIDTH'(DEF_EXC_VEC2),
    parameter logic [WIDTH-1:0] EXC_VEC3 = WIDTH'(DEF_EXC_VEC3)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SELW-1:0]       pc_src,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic                  pc_write,
    input  logic                  pc_write_cond,
    input  logic                  cond_true,
    input  logic                  exc_req,
    input  logic [1:0]            exc_cause,
    output logic [WIDTH-1:0]      pc_out,
    output logic [WIDTH-1:0]      epc_out,
    output logic [1:0]            cause_out,
    output logic                  exc_busy,
    output logic                  sel_err
);

    state_t           state, next_state;
    logic [WIDTH-1:0] tgt, exc_vec;
    logic             valid, load, bad_align, take_exc, do_load;
    logic [1:0]       cur_cause, pend_cause;
    logic             pending;

    pc_src_mux #(.NSRC(NSRC), .WIDTH(WIDTH), .SELW(SELW)) u_mux (
        .sel     (pc_src),
        .data_in (src_data),
        .data    (tgt),
        .valid   (valid)
    );

    assign load = pc_write | (pc_write_cond & cond_true);

`ifdef PC_PC_ALIGN_CHECK_EN
    assign bad_align = tgt[1:0] != 2'b00;
`else
    assign bad_align = 1'b0;
`endif

    // In RUN, a queued request is serviced first, then a fresh request, then
    // a misaligned load; any of these discards the load.
    always_comb begin
        take_exc = pending | exc_req | (load & valid & bad_align);
        do_load  = load & valid & ~take_exc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= RUN;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = (state == RUN)      ? (take_exc ? EXC_SAVE : RUN) :
                     (state == EXC_SAVE) ? EXC_JUMP : RUN;
    end

    always_comb begin
        exc_busy = state != RUN;
        exc_vec  = (cur_cause == 2'd0) ? EXC_VEC0 :
                   (cur_cause == 2'd1) ? EXC_VEC1 :
                   (cur_cause == 2'd2) ? EXC_VEC2 : EXC_VEC3;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_out     <= RESET_PC;
            epc_out    <= '0;
            cause_out  <= '0;
            cur_cause  <= '0;
            pend_cause <= '0;
            pending    <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            sel_err <= (state == RUN) && load && !valid && !pending && !exc_req;
            case (state)
                RUN: begin
                    if (pending) begin
                        cur_cause <= pend_cause;
                        pending   <= 1'b0;
                    end else if (exc_req)
                        cur_cause <= exc_cause;
                    else if (take_exc)
                        cur_cause <= ALIGN;
                    else if (do_load)
                        pc_out <= tgt;
                end
                EXC_SAVE: begin
                    epc_out   <= pc_out;
                    cause_out <= cur_cause;
                end
                default: pc_out <= exc_vec;
            endcase
            // One-deep queue for requests arriving mid-sequence; extras drop.
            if (state != RUN && exc_req && !pending) begin
                pending    <= 1'b1;
                pend_cause <= exc_cause;
            end
        end
    end

endmodule
